// File: rtl/map_table_ss_pkg.sv
// Shared types, sizes and helpers for the superscalar rename map table.
// Optional same-cycle CDB ready bypass: MAP_TABLE_CDB_BYPASS_EN.
package map_table_ss_pkg;

    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned NUM_PR        = 64;
    localparam int unsigned DISP_WIDTH    = 2;
    localparam int unsigned CDB_WIDTH     = 2;
    localparam int unsigned NUM_CKPT      = 4;
    localparam int unsigned AR_W          = 5;
    localparam int unsigned PR_W          = $clog2(NUM_PR);
    localparam int unsigned CKPT_W        = $clog2(NUM_CKPT);

    typedef logic [AR_W-1:0]                 areg_t;
    typedef logic [PR_W-1:0]                 ptag_t;
    typedef logic [CKPT_W-1:0]               ckpt_id_t;
    typedef logic [CKPT_W:0]                 ckpt_cnt_t;
    typedef logic [CDB_WIDTH-1:0][PR_W-1:0]  cdb_tags_t;

    typedef struct packed {
        ptag_t idx;
        logic  ready;
    } T_t;

    typedef T_t [NUM_ARCH_REGS-1:0] map_t;

    localparam areg_t ZERO_REG = areg_t'(NUM_ARCH_REGS - 1);

    typedef struct packed {
        logic  valid;
        areg_t reg_dest;
        areg_t reg_a;
        areg_t reg_b;
        ptag_t T_new;
        logic  ckpt_req;
    } MAP_TABLE_SS_PACKET_IN;

    typedef struct packed {
        ptag_t    T1;
        ptag_t    T2;
        logic     T1_ready;
        logic     T2_ready;
        ptag_t    Told;
        ckpt_id_t ckpt_idx;
    } MAP_TABLE_SS_PACKET_OUT;

    typedef struct packed {
        ckpt_id_t  head;
        ckpt_id_t  tail;
        ckpt_cnt_t count;
    } ckpt_ptr_t;

    localparam ckpt_ptr_t CKPT_RESET = '0;

    function automatic map_t map_reset_f();
        map_t m;
        for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
            m[i].idx   = ptag_t'(i);
            m[i].ready = 1'b1;
        end
        return m;
    endfunction

    localparam map_t MAP_TABLE_RESET = map_reset_f();

    function automatic logic cdb_match(ptag_t tag, logic [CDB_WIDTH-1:0] v, cdb_tags_t t);
        logic hit;
        hit = 1'b0;
        for (int unsigned c = 0; c < CDB_WIDTH; c++)
            hit = hit | (v[c] && (t[c] == tag));
        return hit;
    endfunction

    // Every matching entry is woken, not just the first one found.
    function automatic map_t apply_cdb(map_t m, logic [CDB_WIDTH-1:0] v, cdb_tags_t t);
        map_t r;
        r = m;
        for (int unsigned i = 0; i < NUM_ARCH_REGS; i++)
            if (cdb_match(m[i].idx, v, t)) r[i].ready = 1'b1;
        return r;
    endfunction

    function automatic T_t read_map(map_t m, areg_t r);
        T_t e;
        e = m[r];
        if (r == ZERO_REG) e = '{idx: ptag_t'(ZERO_REG), ready: 1'b1};
        return e;
    endfunction

endpackage

// File: rtl/map_table_ss_if.sv
// Dispatch / CDB / branch-unit bundle of the rename map table.
interface map_table_ss_if import map_table_ss_pkg::*; ();

    logic     [DISP_WIDTH-1:0] dispatch_valid;
    areg_t    [DISP_WIDTH-1:0] reg_dest;
    areg_t    [DISP_WIDTH-1:0] reg_a;
    areg_t    [DISP_WIDTH-1:0] reg_b;
    ptag_t    [DISP_WIDTH-1:0] T_new;
    logic     [DISP_WIDTH-1:0] ckpt_req;
    logic     [CDB_WIDTH-1:0]  CDB_valid;
    ptag_t    [CDB_WIDTH-1:0]  CDB_T;
    logic                      rollback_en;
    ckpt_id_t                  rollback_ckpt;
    logic                      release_en;
    ptag_t    [DISP_WIDTH-1:0] T1;
    ptag_t    [DISP_WIDTH-1:0] T2;
    logic     [DISP_WIDTH-1:0] T1_ready;
    logic     [DISP_WIDTH-1:0] T2_ready;
    ptag_t    [DISP_WIDTH-1:0] Told;
    ckpt_id_t [DISP_WIDTH-1:0] ckpt_idx;
    logic                      ckpt_full;

    modport master (
        output dispatch_valid, reg_dest, reg_a, reg_b, T_new, ckpt_req,
               CDB_valid, CDB_T, rollback_en, rollback_ckpt, release_en,
        input  T1, T2, T1_ready, T2_ready, Told, ckpt_idx, ckpt_full
    );

    modport slave (
        input  dispatch_valid, reg_dest, reg_a, reg_b, T_new, ckpt_req,
               CDB_valid, CDB_T, rollback_en, rollback_ckpt, release_en,
        output T1, T2, T1_ready, T2_ready, Told, ckpt_idx, ckpt_full
    );

endinterface

// File: rtl/map_table_ckpt_stack.sv
// Circular checkpoint stack: snapshot storage, head/tail/count, CDB wakeup of
// live snapshots and full flag.
module map_table_ckpt_stack import map_table_ss_pkg::*; (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 alloc_i,
    input  map_t                 alloc_map_i,
    input  logic                 rollback_en_i,
    input  ckpt_id_t             rollback_ckpt_i,
    input  logic                 release_en_i,
    input  logic [CDB_WIDTH-1:0] cdb_valid_i,
    input  cdb_tags_t            cdb_t_i,
    output map_t                 rb_map_o,
    output ckpt_id_t             tail_o,
    output logic                 full_o
);

    map_t [NUM_CKPT-1:0] snap_q, snap_d;
    ckpt_ptr_t           ptr_q, ptr_d;
    logic [NUM_CKPT-1:0] live;
    logic                alloc_ok, release_ok;

    // Snapshot validity is derived from head/count rather than stored.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CKPT; i++)
            live[i] = ckpt_cnt_t'(ckpt_id_t'(ckpt_id_t'(i) - ptr_q.head)) < ptr_q.count;
    end

    always_comb begin
        full_o     = (ptr_q.count == ckpt_cnt_t'(NUM_CKPT));
        alloc_ok   = alloc_i && !full_o && !rollback_en_i;
        release_ok = release_en_i && (ptr_q.count != '0);
        snap_d     = snap_q;
        ptr_d      = ptr_q;
        for (int unsigned i = 0; i < NUM_CKPT; i++)
            if (live[i]) snap_d[i] = apply_cdb(snap_q[i], cdb_valid_i, cdb_t_i);
        if (alloc_ok) snap_d[ptr_q.tail] = alloc_map_i;
        if (release_ok) ptr_d.head = ptr_q.head + ckpt_id_t'(1);
        if (rollback_en_i) begin
            ptr_d.tail  = rollback_ckpt_i;
            ptr_d.count = ckpt_cnt_t'(ckpt_id_t'(rollback_ckpt_i - ptr_d.head));
        end else begin
            ptr_d.tail  = ptr_q.tail + ckpt_id_t'(alloc_ok);
            ptr_d.count = ptr_q.count + ckpt_cnt_t'(alloc_ok) - ckpt_cnt_t'(release_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_q <= '0;
            ptr_q  <= CKPT_RESET;
        end else if (en_i) begin
            snap_q <= snap_d;
            ptr_q  <= ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && en_i) begin
            assert (!(alloc_i && full_o && !rollback_en_i));
            assert (!(rollback_en_i && !live[rollback_ckpt_i]));
            assert (!(release_en_i && ptr_q.count == '0));
            assert (!(release_en_i && rollback_en_i && rollback_ckpt_i == ptr_q.head));
        end
    end

    assign rb_map_o = snap_q[rollback_ckpt_i];
    assign tail_o   = ptr_q.tail;

endmodule

// File: rtl/map_table_ss.sv
// N-wide rename map table with intra-group forwarding and branch checkpoints.
// Optional same-cycle CDB ready bypass: MAP_TABLE_CDB_BYPASS_EN.
module map_table_ss import map_table_ss_pkg::*; (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           en_i,
    map_table_ss_if.slave  bus
);

    map_t                                    map_q, map_d, alloc_map, rb_map;
    MAP_TABLE_SS_PACKET_IN  [DISP_WIDTH-1:0] pin;
    MAP_TABLE_SS_PACKET_OUT [DISP_WIDTH-1:0] pout;
    T_t                     [DISP_WIDTH-1:0] src1, src2, srco;
    logic                   [DISP_WIDTH-1:0] byp1, byp2;
    logic                                    alloc, full;
    ckpt_id_t                                tail;

    always_comb begin
        for (int unsigned j = 0; j < DISP_WIDTH; j++)
            pin[j] = '{valid: bus.dispatch_valid[j], reg_dest: bus.reg_dest[j],
                       reg_a: bus.reg_a[j], reg_b: bus.reg_b[j],
                       T_new: bus.T_new[j], ckpt_req: bus.ckpt_req[j]};
    end

    // Later earlier-slot matches overwrite, so the youngest producer wins.
    always_comb begin
        for (int unsigned j = 0; j < DISP_WIDTH; j++) begin
            src1[j] = read_map(map_q, pin[j].reg_a);
            src2[j] = read_map(map_q, pin[j].reg_b);
            srco[j] = read_map(map_q, pin[j].reg_dest);
            for (int unsigned k = 0; k < j; k++) begin
                if (pin[k].valid && pin[k].reg_dest != ZERO_REG) begin
                    if (pin[k].reg_dest == pin[j].reg_a)    src1[j] = '{idx: pin[k].T_new, ready: 1'b0};
                    if (pin[k].reg_dest == pin[j].reg_b)    src2[j] = '{idx: pin[k].T_new, ready: 1'b0};
                    if (pin[k].reg_dest == pin[j].reg_dest) srco[j] = '{idx: pin[k].T_new, ready: 1'b0};
                end
            end
        end
    end

`ifdef MAP_TABLE_CDB_BYPASS_EN
    always_comb begin
        for (int unsigned j = 0; j < DISP_WIDTH; j++) begin
            byp1[j] = cdb_match(src1[j].idx, bus.CDB_valid, bus.CDB_T);
            byp2[j] = cdb_match(src2[j].idx, bus.CDB_valid, bus.CDB_T);
            for (int unsigned k = 0; k < j; k++) begin
                if (pin[k].valid && pin[k].reg_dest != ZERO_REG) begin
                    if (pin[k].reg_dest == pin[j].reg_a) byp1[j] = 1'b0;
                    if (pin[k].reg_dest == pin[j].reg_b) byp2[j] = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        byp1 = '0;
        byp2 = '0;
    end
`endif

    // Snapshot for a branch slot captures writes up to and including that slot.
    always_comb begin
        map_d     = map_q;
        alloc     = 1'b0;
        alloc_map = map_q;
        if (bus.rollback_en) begin
            map_d = rb_map;
        end else begin
            for (int unsigned j = 0; j < DISP_WIDTH; j++) begin
                if (pin[j].valid) begin
                    if (pin[j].reg_dest != ZERO_REG)
                        map_d[pin[j].reg_dest] = '{idx: pin[j].T_new, ready: 1'b0};
                    if (pin[j].ckpt_req) begin
                        alloc     = 1'b1;
                        alloc_map = map_d;
                    end
                end
            end
        end
        alloc_map = apply_cdb(alloc_map, bus.CDB_valid, bus.CDB_T);
        map_d     = apply_cdb(map_d, bus.CDB_valid, bus.CDB_T);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   map_q <= MAP_TABLE_RESET;
        else if (en_i) map_q <= map_d;
    end

    map_table_ckpt_stack u_ckpt (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .en_i            (en_i),
        .alloc_i         (alloc),
        .alloc_map_i     (alloc_map),
        .rollback_en_i   (bus.rollback_en),
        .rollback_ckpt_i (bus.rollback_ckpt),
        .release_en_i    (bus.release_en),
        .cdb_valid_i     (bus.CDB_valid),
        .cdb_t_i         (bus.CDB_T),
        .rb_map_o        (rb_map),
        .tail_o          (tail),
        .full_o          (full)
    );

    always_comb begin
        for (int unsigned j = 0; j < DISP_WIDTH; j++) begin
            pout[j] = '{T1: src1[j].idx, T2: src2[j].idx,
                        T1_ready: src1[j].ready | byp1[j], T2_ready: src2[j].ready | byp2[j],
                        Told: srco[j].idx, ckpt_idx: tail};
            bus.T1[j]       = pout[j].T1;
            bus.T2[j]       = pout[j].T2;
            bus.T1_ready[j] = pout[j].T1_ready;
            bus.T2_ready[j] = pout[j].T2_ready;
            bus.Told[j]     = pout[j].Told;
            bus.ckpt_idx[j] = pout[j].ckpt_idx;
        end
        bus.ckpt_full = full;
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && en_i) begin
            assert ($countones(bus.dispatch_valid & bus.ckpt_req) <= 1);
            if (!bus.rollback_en)
                for (int unsigned j = 0; j < DISP_WIDTH; j++)
                    for (int unsigned c = 0; c < CDB_WIDTH; c++)
                        assert (!(pin[j].valid && pin[j].reg_dest != ZERO_REG &&
                                  bus.CDB_valid[c] && bus.CDB_T[c] == pin[j].T_new));
        end
    end

endmodule

// File: tb/tb_map_table_ss.sv
// Directed bench for map_table_ss: expectations queued at drive time, popped and
// compared on the falling edge while the combinational outputs are stable.
module tb_map_table_ss;
    import map_table_ss_pkg::*;

    localparam int unsigned F_T1 = 0, F_T2 = 1, F_R1 = 2, F_R2 = 3,
                            F_TOLD = 4, F_CK = 5, F_FULL = 6;
    localparam logic [31:0] BYP =
`ifdef MAP_TABLE_CDB_BYPASS_EN
        32'd1;
`else
        32'd0;
`endif

    typedef struct {
        string       tag;
        int unsigned f;
        int unsigned s;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    map_table_ss_if bus ();

    map_table_ss dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(int unsigned f, int unsigned s);
        case (f)
            F_T1:    return 32'(bus.T1[s]);
            F_T2:    return 32'(bus.T2[s]);
            F_R1:    return 32'(bus.T1_ready[s]);
            F_R2:    return 32'(bus.T2_ready[s]);
            F_TOLD:  return 32'(bus.Told[s]);
            F_CK:    return 32'(bus.ckpt_idx[s]);
            default: return 32'(bus.ckpt_full);
        endcase
    endfunction

    task automatic idle();
        bus.dispatch_valid = '0;
        bus.reg_dest       = '0;
        bus.reg_a          = '0;
        bus.reg_b          = '0;
        bus.T_new          = '0;
        bus.ckpt_req       = '0;
        bus.CDB_valid      = '0;
        bus.CDB_T          = '0;
        bus.rollback_en    = 1'b0;
        bus.rollback_ckpt  = '0;
        bus.release_en     = 1'b0;
    endtask

    task automatic exp_v(string tag, int unsigned f, int unsigned s, logic [31:0] v);
        sb.push_back('{tag: tag, f: f, s: s, exp: v});
    endtask

    task automatic check_now();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.f, e.s);
            n_checks++;
            assert (obs === e.exp) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1 en = 1'b1;

        // Reset state
        idle();
        bus.reg_a[0] = 5'd5; bus.reg_b[0] = 5'd31; bus.reg_dest[0] = 5'd9; bus.reg_dest[1] = 5'd31;
        exp_v("rst_T1", F_T1, 0, 5);   exp_v("rst_T1r", F_R1, 0, 1);
        exp_v("rst_T2", F_T2, 0, 31);  exp_v("rst_T2r", F_R2, 0, 1);
        exp_v("rst_Told0", F_TOLD, 0, 9); exp_v("rst_Told1_zero", F_TOLD, 1, 31);
        exp_v("rst_ck", F_CK, 0, 0);   exp_v("rst_full", F_FULL, 0, 0);
        check_now();

        // Dual dispatch with intra-group forwarding
        idle();
        bus.dispatch_valid = 2'b11;
        bus.reg_dest[0] = 5'd3; bus.T_new[0] = 6'd40;
        bus.reg_dest[1] = 5'd4; bus.reg_a[1] = 5'd3; bus.reg_b[1] = 5'd3; bus.T_new[1] = 6'd41;
        exp_v("fwd_T1", F_T1, 1, 40); exp_v("fwd_T2", F_T2, 1, 40);
        exp_v("fwd_T1r", F_R1, 1, 0); exp_v("fwd_T2r", F_R2, 1, 0);
        exp_v("fwd_Told0", F_TOLD, 0, 3); exp_v("fwd_Told1", F_TOLD, 1, 4);
        check_now();

        idle();
        bus.reg_a[0] = 5'd3; bus.reg_b[0] = 5'd4;
        exp_v("map3", F_T1, 0, 40); exp_v("map3_r", F_R1, 0, 0);
        exp_v("map4", F_T2, 0, 41); exp_v("map4_r", F_R2, 0, 0);
        check_now();

        // Same destination in both slots
        idle();
        bus.dispatch_valid = 2'b11;
        bus.reg_dest[0] = 5'd7; bus.T_new[0] = 6'd50;
        bus.reg_dest[1] = 5'd7; bus.T_new[1] = 6'd51;
        exp_v("same_Told0", F_TOLD, 0, 7); exp_v("same_Told1", F_TOLD, 1, 50);
        check_now();

        // Map read, CDB on port 1 for r4, forwarding on slot 1
        idle();
        bus.reg_a[0] = 5'd7; bus.reg_b[0] = 5'd4;
        bus.dispatch_valid = 2'b01; bus.reg_dest[0] = 5'd10; bus.T_new[0] = 6'd55;
        bus.reg_a[1] = 5'd10; bus.reg_b[1] = 5'd4;
        bus.CDB_valid = 2'b10; bus.CDB_T[1] = 6'd41;
        exp_v("map7", F_T1, 0, 51); exp_v("map7_r", F_R1, 0, 0);
        exp_v("byp_T2", F_T2, 0, 41); exp_v("byp_T2r", F_R2, 0, BYP);
        exp_v("fwd10", F_T1, 1, 55); exp_v("fwd10_r", F_R1, 1, 0);
        exp_v("byp_s1_T2r", F_R2, 1, BYP);
        check_now();

        idle();
        bus.reg_b[0] = 5'd4; bus.reg_a[0] = 5'd10;
        exp_v("woke4_r", F_R2, 0, 1); exp_v("map10", F_T1, 0, 55); exp_v("map10_r", F_R1, 0, 0);
        check_now();

        // en low: dispatch and CDB must not change state
        idle();
        en = 1'b0;
        bus.dispatch_valid = 2'b01; bus.reg_dest[0] = 5'd5; bus.T_new[0] = 6'd60;
        bus.CDB_valid = 2'b01; bus.CDB_T[0] = 6'd55;
        exp_v("en0_Told", F_TOLD, 0, 5);
        check_now();
        idle();
        en = 1'b1;
        bus.reg_a[0] = 5'd5; bus.reg_b[0] = 5'd10;
        exp_v("en0_map5", F_T1, 0, 5); exp_v("en0_map5_r", F_R1, 0, 1);
        exp_v("en0_map10_r", F_R2, 0, 0);
        check_now();

        // Checkpoint in slot 0, slot 1 write excluded from snapshot
        idle();
        bus.dispatch_valid = 2'b11; bus.ckpt_req = 2'b01;
        bus.reg_dest[0] = 5'd3; bus.T_new[0] = 6'd21;
        bus.reg_dest[1] = 5'd12; bus.T_new[1] = 6'd20;
        exp_v("ck_idx", F_CK, 0, 0); exp_v("ck_full", F_FULL, 0, 0);
        exp_v("ck_Told0", F_TOLD, 0, 40);
        check_now();

        idle();
        bus.CDB_valid = 2'b01; bus.CDB_T[0] = 6'd21;
        bus.reg_a[0] = 5'd3; bus.reg_a[1] = 5'd12;
        exp_v("ck_map3", F_T1, 0, 21); exp_v("ck_map3_r", F_R1, 0, BYP);
        exp_v("ck_map12", F_T1, 1, 20); exp_v("ck_tail1", F_CK, 0, 1);
        check_now();

        idle();
        bus.rollback_en = 1'b1; bus.rollback_ckpt = 2'd0;
        bus.dispatch_valid = 2'b01; bus.reg_dest[0] = 5'd13; bus.T_new[0] = 6'd22;
        bus.reg_a[1] = 5'd3;
        exp_v("rb_pre_map3", F_T1, 1, 21); exp_v("rb_pre_map3_r", F_R1, 1, 1);
        check_now();

        idle();
        bus.reg_a[0] = 5'd3; bus.reg_b[0] = 5'd12; bus.reg_a[1] = 5'd13;
        exp_v("rb_map3", F_T1, 0, 21); exp_v("rb_map3_r", F_R1, 0, 1);
        exp_v("rb_map12", F_T2, 0, 12); exp_v("rb_map12_r", F_R2, 0, 1);
        exp_v("rb_map13", F_T1, 1, 13); exp_v("rb_tail", F_CK, 0, 0);
        exp_v("rb_full", F_FULL, 0, 0);
        check_now();

        // Fill all checkpoints
        for (int i = 0; i < 4; i++) begin
            idle();
            bus.dispatch_valid = 2'b01; bus.ckpt_req = 2'b01;
            bus.reg_dest[0] = 5'd14; bus.T_new[0] = 6'(56 + i);
            exp_v("fill_idx", F_CK, 0, 32'(i)); exp_v("fill_full", F_FULL, 0, 0);
            check_now();
        end

        idle();
        bus.reg_a[0] = 5'd14;
        exp_v("full_set", F_FULL, 0, 1); exp_v("full_map14", F_T1, 0, 59);
        check_now();

        idle();
        bus.release_en = 1'b1;
        exp_v("rel_full_same_cycle", F_FULL, 0, 1);
        check_now();

        idle();
        bus.dispatch_valid = 2'b10; bus.ckpt_req = 2'b10;
        bus.reg_dest[1] = 5'd15; bus.T_new[1] = 6'd62;
        exp_v("rel_full_clear", F_FULL, 0, 0); exp_v("wrap_idx", F_CK, 1, 0);
        check_now();

        idle();
        exp_v("refull", F_FULL, 0, 1);
        check_now();

        // Rollback and release together
        idle();
        bus.rollback_en = 1'b1; bus.rollback_ckpt = 2'd2; bus.release_en = 1'b1;
        exp_v("rbrel_full", F_FULL, 0, 1);
        check_now();

        idle();
        bus.reg_a[0] = 5'd14; bus.reg_b[0] = 5'd15;
        exp_v("rbrel_full_after", F_FULL, 0, 0); exp_v("rbrel_tail", F_CK, 0, 2);
        exp_v("rbrel_map14", F_T1, 0, 58); exp_v("rbrel_map14_r", F_R1, 0, 0);
        exp_v("rbrel_map15", F_T2, 0, 15); exp_v("rbrel_map15_r", F_R2, 0, 1);
        check_now();

        // Zero register is never renamed
        idle();
        bus.dispatch_valid = 2'b01; bus.reg_dest[0] = 5'd31; bus.T_new[0] = 6'd61;
        bus.reg_a[1] = 5'd31; bus.reg_b[1] = 5'd31;
        exp_v("zero_Told", F_TOLD, 0, 31);
        exp_v("zero_T1", F_T1, 1, 31); exp_v("zero_T1r", F_R1, 1, 1);
        exp_v("zero_T2", F_T2, 1, 31);
        check_now();

        idle();
        bus.reg_a[0] = 5'd31;
        exp_v("zero_map", F_T1, 0, 31); exp_v("zero_map_r", F_R1, 0, 1);
        check_now();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/map_table_ss.md
Name: map_table_ss

Overview:
- N-wide superscalar rename map table with a branch checkpoint stack; successor to the single-issue map table.
- Renames up to DISP_WIDTH instructions per cycle with intra-group dependency forwarding.
- Accepts CDB_WIDTH wakeups per cycle; snapshots live checkpoints and keeps their ready bits current.
- Sits between decode/dispatch and RS/ROB; free list supplies new tags, branch unit drives rollback and release.

Parameters:
- NUM_ARCH_REGS, 32, architectural registers; index NUM_ARCH_REGS-1 is the zero register.
- NUM_PR, 64, physical registers; tag width PR_W = $clog2(NUM_PR).
- DISP_WIDTH, 2, rename slots per cycle.
- CDB_WIDTH, 2, CDB broadcast ports.
- NUM_CKPT, 4, checkpoint entries; power of two.

Ports:
- clock input 1: rising-edge clock.
- reset input 1: asynchronous, active-low.
- en input 1: state update enable.
- dispatch_valid input DISP_WIDTH: slot valid.
- reg_dest/reg_a/reg_b input DISP_WIDTH x 5: per-slot architectural indices.
- T_new input DISP_WIDTH x PR_W: free-list tag per slot.
- ckpt_req input DISP_WIDTH: slot is a branch needing a checkpoint.
- CDB_valid input CDB_WIDTH; CDB_T input CDB_WIDTH x PR_W: completing tags.
- rollback_en input 1; rollback_ckpt input $clog2(NUM_CKPT): mispredict restore.
- release_en input 1: oldest checkpoint retired (branch correct).
- T1/T2 output DISP_WIDTH x PR_W; T1_ready/T2_ready output DISP_WIDTH.
- Told output DISP_WIDTH x PR_W: previous mapping of reg_dest.
- ckpt_idx output DISP_WIDTH x $clog2(NUM_CKPT): checkpoint id assigned to branch slot.
- ckpt_full output 1: no free checkpoint.

Behaviour:
- Reset, async while low: map[i] = {tag i, ready 1}; checkpoint head = tail = count = 0; all snapshots invalid. Outputs after reset: T1 = reg_a, T1_ready = 1, Told = reg_dest, ckpt_full = 0.
- Outputs are combinational, zero latency; state updates only on clock edges with en = 1 and reset high. With en = 0, state holds.
- Slot j sources: take the highest valid earlier slot k<j with reg_dest[k] == source; yield T_new[k], ready = 0. Otherwise the map entry.
- Told[j] follows the same forwarding rule using reg_dest[j].
- Zero register is never renamed, always reads tag NUM_ARCH_REGS-1 with ready 1; its Told is that tag.
- Next map: for each valid slot, in order, map[reg_dest] = {T_new, 0}; the later slot wins on a same-dest conflict.
- CDB: any entry whose tag matches a valid CDB_T is set ready. This applies to all entries, not first match, and to the map and every valid snapshot.
- CDB ready-setting applies after dispatch writes. A dispatch writing tag X while CDB broadcasts X is a protocol violation; assert in sim.
- Checkpoint: at most one ckpt_req per cycle, otherwise assert. The snapshot at tail holds map state including slots 0..j, excluding later slots. ckpt_idx[j] = tail; tail++, count++.
- ckpt_req while ckpt_full: request ignored and asserted in sim. Upstream must stall on ckpt_full.
- Rollback, priority over dispatch (all dispatch ignored that cycle):
  - map = snapshot[rollback_ckpt], then same-cycle CDB applied.
  - tail = rollback_ckpt; count recomputed as (tail - head) mod NUM_CKPT.
  - Rollback of a free checkpoint asserts.
- Release: head++, count--. Release with count 0 is ignored and asserted.
- Release and rollback in the same cycle are allowed only if rollback_ckpt != head; both are applied.
- Release and checkpoint allocation in the same cycle while full: allocation is still refused, since ckpt_full is from the current state.
- Pointers wrap modulo NUM_CKPT; ckpt_full = (count == NUM_CKPT).

Optional Feature:
- Macro MAP_TABLE_CDB_BYPASS_EN.
- Defined: T1_ready/T2_ready also assert when the forwarded tag matches a valid same-cycle CDB_T. Intra-group forwarded tags are excluded.
- Undefined: ready reflects registered state only; wakeup becomes visible the next cycle.

Decomposition:
- Shared package holds:
  - T_t {idx, ready}.
  - MAP_TABLE_SS_PACKET_IN/OUT structs.
  - ZERO_REG constant.
  - MAP_TABLE_RESET and CKPT_RESET constants.
  - PR_W / CKPT_W localparams.
- Sub-module map_table_ckpt_stack holds snapshot storage, head/tail/count, CDB update of snapshots, and full logic. The top module holds the live map, rename forwarding, and outputs.

Test Plan:
- Reset then read: reg_a = 5 -> T1 = 5, T1_ready = 1, ckpt_full = 0.
- Dual dispatch r3<-T40, then r4 = r3+r3 with T41 -> slot1 T1 = T2 = 40, ready 0, Told[1] = 4. Next cycle map[3] = 40, map[4] = 41.
- Same dest both slots (r7<-T50, r7<-T51) -> Told[0] = 7, Told[1] = 50, map[7] = 51.
- CDB T40 while ckpt0 holds r3 = 40 not ready; then rollback_ckpt = 0 -> map[3] = {40, 1}, tail = 0.
- Allocate 4 checkpoints -> ckpt_full = 1; 5th ckpt_req ignored; release -> ckpt_full = 0, head = 1, count = 3.
- With MAP_TABLE_CDB_BYPASS_EN: map[2] = {45, 0}, CDB T45, reg_a = 2 -> T1_ready = 1 that cycle. Without the macro -> 0, then 1 next cycle.
